// File: rtl/fast_mult_arbiter_if.sv
// Handshake bundle for the two-requester 4x4 multiplier arbiter.
// Signal names keep the flat io_* naming so the arbiter's port map stays recognisable.
interface fast_mult_arbiter_if;
    logic       io_req0_valid;
    logic       io_req0_ready;
    logic [3:0] io_req0_lhs;
    logic [3:0] io_req0_rhs;
    logic       io_req1_valid;
    logic       io_req1_ready;
    logic [3:0] io_req1_lhs;
    logic [3:0] io_req1_rhs;
    logic       io_resp0_valid;
    logic       io_resp0_ready;
    logic [7:0] io_resp0_data;
    logic       io_resp1_valid;
    logic       io_resp1_ready;
    logic [7:0] io_resp1_data;
    logic       io_busy;

    modport master (
        output io_req0_valid, io_req0_lhs, io_req0_rhs,
        output io_req1_valid, io_req1_lhs, io_req1_rhs,
        output io_resp0_ready, io_resp1_ready,
        input  io_req0_ready, io_req1_ready,
        input  io_resp0_valid, io_resp0_data,
        input  io_resp1_valid, io_resp1_data,
        input  io_busy
    );

    modport slave (
        input  io_req0_valid, io_req0_lhs, io_req0_rhs,
        input  io_req1_valid, io_req1_lhs, io_req1_rhs,
        input  io_resp0_ready, io_resp1_ready,
        output io_req0_ready, io_req1_ready,
        output io_resp0_valid, io_resp0_data,
        output io_resp1_valid, io_resp1_data,
        output io_busy
    );
endinterface

// File: rtl/fast_mult_arbiter.sv
// Two-requester round-robin front end to a table-driven 4x4 multiplier with a
// single result slot; a draining slot can accept a new grant in the same cycle.
module fast_mult_arbiter (
    input  logic                  clk,
    input  logic                  reset,
    fast_mult_arbiter_if.slave    io
);

    logic       busy_r;
    logic       owner_r;
    logic [7:0] data_r;
    logic       ptr_r;

    logic       busy_nxt_s;
    logic       owner_nxt_s;
    logic [7:0] data_nxt_s;
    logic       ptr_nxt_s;

    logic [7:0] prod_table_s [256];
    logic       drain_s;
    logic       free_s;
    logic       winner_s;
    logic       grant_s;
    logic [3:0] lhs_s;
    logic [3:0] rhs_s;
    logic [7:0] prod_s;

    // Constant product table, entry {lhs,rhs} = lhs*rhs
    always_comb begin
        for (int i = 0; i < 256; i++) begin
            prod_table_s[i] = 8'((i >> 4) * (i & 15));
        end
    end

    // Slot availability, arbitration and operand selection
    always_comb begin
        drain_s = 1'b0;
        if (owner_r) begin
            drain_s = busy_r & io.io_resp1_ready;
        end else begin
            drain_s = busy_r & io.io_resp0_ready;
        end
        free_s = ~busy_r | drain_s;

        // With no requester valid the pointer still names a single winner,
        // so at most one ready is ever offered.
        winner_s = ptr_r;
        if (io.io_req0_valid && !io.io_req1_valid) begin
            winner_s = 1'b0;
        end else if (io.io_req1_valid && !io.io_req0_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = ptr_r;
        end

        grant_s = 1'b0;
        lhs_s   = 4'h0;
        rhs_s   = 4'h0;
        if (winner_s) begin
            grant_s = free_s & io.io_req1_valid;
            lhs_s   = io.io_req1_lhs;
            rhs_s   = io.io_req1_rhs;
        end else begin
            grant_s = free_s & io.io_req0_valid;
            lhs_s   = io.io_req0_lhs;
            rhs_s   = io.io_req0_rhs;
        end
        prod_s = prod_table_s[{lhs_s, rhs_s}];
    end

    // Next-state: grant reloads the slot (even while draining), drain alone empties it
    always_comb begin
        busy_nxt_s  = busy_r;
        owner_nxt_s = owner_r;
        data_nxt_s  = data_r;
        ptr_nxt_s   = ptr_r;
        if (grant_s) begin
            busy_nxt_s  = 1'b1;
            owner_nxt_s = winner_s;
            data_nxt_s  = prod_s;
            ptr_nxt_s   = ~winner_s;
        end else if (drain_s) begin
            busy_nxt_s  = 1'b0;
        end else begin
            busy_nxt_s  = busy_r;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= 1'b0;
            owner_r <= 1'b0;
            data_r  <= 8'h00;
            ptr_r   <= 1'b0;
        end else begin
            busy_r  <= busy_nxt_s;
            owner_r <= owner_nxt_s;
            data_r  <= data_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Handshake outputs, all suppressed while reset is asserted
    always_comb begin
        io.io_req0_ready  = 1'b0;
        io.io_req1_ready  = 1'b0;
        io.io_resp0_valid = 1'b0;
        io.io_resp1_valid = 1'b0;
        if (reset) begin
            io.io_req0_ready  = 1'b0;
            io.io_req1_ready  = 1'b0;
            io.io_resp0_valid = 1'b0;
            io.io_resp1_valid = 1'b0;
        end else begin
            io.io_req0_ready  = free_s & ~winner_s;
            io.io_req1_ready  = free_s & winner_s;
            io.io_resp0_valid = busy_r & ~owner_r;
            io.io_resp1_valid = busy_r & owner_r;
        end
        io.io_resp0_data = data_r;
        io.io_resp1_data = data_r;
        io.io_busy       = busy_r;
    end

endmodule

// File: doc/fast_mult_arbiter.md
FAST_MULT_ARBITER -- requirements
Module: fast_mult_arbiter

Interface
REQ-001 SHALL have no parameters; all widths fixed: operands 4 bits, product 8 bits, two requesters.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: io_req0_valid  input  1  requester 0 presents an operand pair.
REQ-005 SHALL have port: io_req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 SHALL have port: io_req0_lhs / io_req0_rhs  input  4 each  requester 0 operands.
REQ-007 SHALL have ports io_req1_valid, io_req1_ready, io_req1_lhs, io_req1_rhs with the same directions, widths and meanings for requester 1.
REQ-008 SHALL have port: io_resp0_valid  output  1  product for requester 0 held.
REQ-009 SHALL have port: io_resp0_ready  input  1  requester 0 takes the product this cycle.
REQ-010 SHALL have port: io_resp0_data  output  8  product for requester 0.
REQ-011 SHALL have ports io_resp1_valid, io_resp1_ready, io_resp1_data with the same meanings for requester 1.
REQ-012 SHALL have port: io_busy  output  1  result slot occupied.

Function
REQ-013 Product SHALL come from a 256-entry x 8-bit lookup table addressed by {lhs, rhs}, entry = lhs*rhs, full 8-bit result, no truncation.
REQ-014 State: one result slot (busy flag, 1-bit owner, 8-bit data) plus 1-bit round-robin priority pointer.
REQ-015 Slot free this cycle (free) = !busy, or busy and the owner's resp_ready is high (drain).
REQ-016 Arbitration: if only one req_valid, that requester wins; if both, the requester named by the pointer wins.
REQ-017 io_reqN_ready SHALL be high only when free and requester N wins (combinational, independent of own req_valid); never both high.
REQ-018 On grant (valid & ready): slot loads table[{lhs,rhs}] and owner=N, busy=1 at next edge; pointer becomes the non-granted index.
REQ-019 Latency: product visible on io_respN_data with io_respN_valid=1 exactly one cycle after the grant cycle.
REQ-020 io_respN_valid = busy & (owner==N); the other response valid SHALL be 0.
REQ-021 io_resp0_data and io_resp1_data SHALL both drive the slot data; consumers qualify with valid.
REQ-022 While valid & !ready, data and owner SHALL be held stable; no new grant.
REQ-023 Drain and grant in the same cycle SHALL both occur: sustained throughput one product per cycle.
REQ-024 Drain without grant: busy clears at next edge.
REQ-025 Pointer SHALL change only on a grant; no grant leaves it unchanged.
REQ-026 Operands of non-granted requester SHALL be ignored; no internal request queueing.
REQ-027 io_busy = busy.

Reset
REQ-028 With reset high at a clk edge: busy=0, owner=0, data=8'h00, pointer=0 (requester 0 wins ties).
REQ-029 During reset-high cycles all req_ready and resp_valid outputs SHALL be 0.
REQ-030 Reset mid-operation SHALL discard any held product without a response; first grant after reset follows REQ-016 from pointer=0.

Verification
REQ-031 Single req: req0 lhs=4'h7 rhs=4'h9 valid one cycle, resp0_ready=1 -> next cycle resp0_valid=1, data=8'h3F, resp1_valid=0.
REQ-032 Tie after reset: both valid (req0 3x5, req1 15x15), resp readys=1 -> cycle1 resp0 data 8'h0F; cycle2 resp1 data 8'hE1; alternation continues while both valid.
REQ-033 Backpressure: resp1 holds 8'h2A (6x7) with resp1_ready=0 for 3 cycles, req0 valid -> req0_ready=0, data stable 3 cycles; on resp1_ready=1 req0 granted same cycle, product next cycle.
REQ-034 Back-to-back: req0 valid 4 consecutive cycles (1x1, 2x2, 15x0, 15x15), resp0_ready=1 -> resp0 data 01,04,00,E1 on consecutive cycles, no bubbles.
REQ-035 Reset mid-op: resp0_valid=1 held with ready=0, assert reset one cycle -> resp0_valid=0, io_busy=0, data=8'h00; then both valid -> req0 granted.
REQ-036 Exhaustive table: all 256 lhs/rhs pairs on req1 -> every resp1_data equals lhs*rhs.
